// File: rtl/rv32_pkg.sv
// Shared RV32 core types: register-file write request and address helpers.
package rv32_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 1 << REG_ADDR_W;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // x0 is hardwired to zero, so writes and busy tracking for it are meaningless.
   function automatic logic reg_is_live(input logic [REG_ADDR_W-1:0] rd);
      return rd != '0;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous in-order FIFO of register-file write requests (MUL/DIV results).
module wb_fifo
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  wb_req_t                  push_data,
   input  logic                     pop,
   output wb_req_t                  head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   wb_req_t         mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         // Simultaneous push and pop leave occupancy unchanged.
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter: WB-stage writes have priority over buffered
// MUL/DIV results; a per-register busy vector tracks outstanding long-latency ops.
module writeback_arbiter
   import rv32_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int XLEN  = rv32_pkg::XLEN
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     pipe_we,
   input  logic [4:0]               pipe_rd,
   input  logic [XLEN-1:0]          pipe_data,
   input  logic                     md_valid,
   output logic                     md_ready,
   input  logic [4:0]               md_rd,
   input  logic [XLEN-1:0]          md_data,
   input  logic                     issue_md,
   input  logic [4:0]               issue_rd,
   input  logic [4:0]               query_rs1,
   input  logic [4:0]               query_rs2,
   input  logic [4:0]               query_rd,
   output logic                     rs1_busy,
   output logic                     rs2_busy,
   output logic                     rd_busy,
   output logic                     rf_write_enable,
   output logic [4:0]               rf_write_reg,
   output logic [XLEN-1:0]          rf_write_data,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   wb_req_t                push_req;
   wb_req_t                head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   fifo_push;
   logic                   pipe_win;
   logic                   fifo_sel;
   logic [NUM_REGS-1:0]    busy;
   logic [NUM_REGS-1:0]    busy_next;

   // Ready depends only on current occupancy; a full FIFO does not accept even
   // when it is popping in the same cycle.
   assign md_ready  = ~fifo_full;
   // Results for x0 complete the handshake but are dropped.
   assign fifo_push = md_valid & md_ready & reg_is_live(md_rd);
   assign push_req  = '{rd: md_rd, data: md_data};

   assign pipe_win  = pipe_we & reg_is_live(pipe_rd);
   assign fifo_sel  = ~pipe_win & ~fifo_empty;

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (push_req),
      .pop       (fifo_sel),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      rf_write_enable = 1'b0;
      rf_write_reg    = '0;
      rf_write_data   = '0;
      if (pipe_win) begin
         rf_write_enable = ~rst;
         rf_write_reg    = pipe_rd;
         rf_write_data   = pipe_data;
      end else if (fifo_sel) begin
         rf_write_enable = ~rst;
         rf_write_reg    = head.rd;
         rf_write_data   = head.data;
      end
   end

   // Clear first, then set, so a same-cycle issue to the retiring register wins.
   always_comb begin
      busy_next = busy;
      if (fifo_sel) begin
         busy_next[head.rd] = 1'b0;
      end
      if (issue_md && reg_is_live(issue_rd)) begin
         busy_next[issue_rd] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
      end else begin
         busy <= busy_next;
      end
   end

   assign rs1_busy = reg_is_live(query_rs1) & busy[query_rs1];
   assign rs2_busy = reg_is_live(query_rs2) & busy[query_rs2];
   assign rd_busy  = reg_is_live(query_rd)  & busy[query_rd];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: expected RF writes go into a queue that a
// negedge monitor drains; state outputs are checked directly after each edge.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_data;
   logic        md_valid;
   logic        md_ready;
   logic [4:0]  md_rd;
   logic [31:0] md_data;
   logic        issue_md;
   logic [4:0]  issue_rd;
   logic [4:0]  query_rs1;
   logic [4:0]  query_rs2;
   logic [4:0]  query_rd;
   logic        rs1_busy;
   logic        rs2_busy;
   logic        rd_busy;
   logic        rf_write_enable;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_write_data;
   logic [2:0]  fifo_count;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   writeback_arbiter #(.DEPTH(4), .XLEN(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .pipe_we         (pipe_we),
      .pipe_rd         (pipe_rd),
      .pipe_data       (pipe_data),
      .md_valid        (md_valid),
      .md_ready        (md_ready),
      .md_rd           (md_rd),
      .md_data         (md_data),
      .issue_md        (issue_md),
      .issue_rd        (issue_rd),
      .query_rs1       (query_rs1),
      .query_rs2       (query_rs2),
      .query_rd        (query_rd),
      .rs1_busy        (rs1_busy),
      .rs2_busy        (rs2_busy),
      .rd_busy         (rd_busy),
      .rf_write_enable (rf_write_enable),
      .rf_write_reg    (rf_write_reg),
      .rf_write_data   (rf_write_data),
      .fifo_count      (fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
      exp_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Inputs change 1 time unit after the rising edge; direct checks follow at +2.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Monitor: every enabled write must match the oldest expected write.
   always @(negedge clk) begin
      if (rf_write_enable === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got x%0d=0x%0h expected no write at %0t",
                     rf_write_reg, rf_write_data, $time);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_reg", {27'd0, rf_write_reg}, {27'd0, e.rd});
            chk("wr_data", rf_write_data, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pipe_we = 0; pipe_rd = 0; pipe_data = 0;
      md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h1111_1111;
      issue_md = 0; issue_rd = 0; query_rs1 = 5'd5; query_rs2 = 0; query_rd = 0;

      // 1. reset with md_valid asserted
      step();
      settle();
      chk("rst_we", {31'd0, rf_write_enable}, 32'd0);
      step();
      rst = 1'b0; md_valid = 1'b0;
      settle();
      chk("rst_ready", {31'd0, md_ready}, 32'd1);
      chk("rst_count", {29'd0, fifo_count}, 32'd0);
      chk("rst_busy", {29'd0, rs1_busy, rs2_busy, rd_busy}, 32'd0);
      chk("rst_we_after", {31'd0, rf_write_enable}, 32'd0);

      // 2. issue / retire x5
      issue_md = 1'b1; issue_rd = 5'd5;
      settle();
      chk("no_issue_fwd", {31'd0, rs1_busy}, 32'd0);
      step();
      issue_md = 1'b0;
      md_valid = 1'b1; md_rd = 5'd5; md_data = 32'hDEAD_BEEF;
      settle();
      chk("busy5_set", {31'd0, rs1_busy}, 32'd1);
      chk("no_bypass", {31'd0, rf_write_enable}, 32'd0);
      expect_wr(5'd5, 32'hDEAD_BEEF);
      step();
      md_valid = 1'b0;
      settle();
      chk("md_count1", {29'd0, fifo_count}, 32'd1);
      chk("md_we", {31'd0, rf_write_enable}, 32'd1);
      chk("busy5_hold", {31'd0, rs1_busy}, 32'd1);
      step();
      settle();
      chk("busy5_clr", {31'd0, rs1_busy}, 32'd0);
      chk("md_count0", {29'd0, fifo_count}, 32'd0);

      // 3. collision: x7 queued while pipeline writes x3 three times
      md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0000_0777;
      step();
      md_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h30 + i;
         expect_wr(5'd3, 32'h30 + i);
         settle();
         chk("coll_count", {29'd0, fifo_count}, 32'd1);
         step();
      end
      pipe_we = 1'b0;
      expect_wr(5'd7, 32'h0000_0777);
      step();
      settle();
      chk("coll_drain", {29'd0, fifo_count}, 32'd0);

      // 4. fill to DEPTH under pipeline pressure, 5th result must wait
      for (int i = 0; i < 4; i++) begin
         pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h100 + i;
         expect_wr(5'd3, 32'h100 + i);
         md_valid = 1'b1; md_rd = 5'(10 + i); md_data = 32'hA0 + i;
         step();
      end
      md_rd = 5'd14; md_data = 32'hA4;
      for (int i = 0; i < 2; i++) begin
         pipe_data = 32'h200 + i;
         expect_wr(5'd3, 32'h200 + i);
         settle();
         chk("full_ready", {31'd0, md_ready}, 32'd0);
         chk("full_count", {29'd0, fifo_count}, 32'd4);
         step();
      end
      pipe_we = 1'b0;
      for (int i = 0; i < 5; i++) expect_wr(5'(10 + i), 32'hA0 + i);
      settle();
      chk("pop1_ready", {31'd0, md_ready}, 32'd0);
      step();
      settle();
      chk("after_pop_ready", {31'd0, md_ready}, 32'd1);
      chk("after_pop_count", {29'd0, fifo_count}, 32'd3);
      step();
      md_valid = 1'b0;
      settle();
      chk("push_pop_count", {29'd0, fifo_count}, 32'd3);
      step(); step(); step();
      settle();
      chk("full_drain", {29'd0, fifo_count}, 32'd0);

      // 5. x0 cases
      md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h55;
      settle();
      chk("x0_ready", {31'd0, md_ready}, 32'd1);
      step();
      md_valid = 1'b0;
      settle();
      chk("x0_md_count", {29'd0, fifo_count}, 32'd0);
      issue_md = 1'b1; issue_rd = 5'd0; query_rs1 = 5'd0;
      step();
      issue_md = 1'b0;
      settle();
      chk("x0_busy", {31'd0, rs1_busy}, 32'd0);
      md_valid = 1'b1; md_rd = 5'd20; md_data = 32'h2020;
      step();
      md_valid = 1'b0;
      pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h999;
      expect_wr(5'd20, 32'h2020);
      step();
      pipe_we = 1'b0;
      settle();
      chk("x0_pipe_pop", {29'd0, fifo_count}, 32'd0);

      // 6. set/clear race on x9, then reset mid-queue
      query_rs2 = 5'd9;
      issue_md = 1'b1; issue_rd = 5'd9;
      step();
      issue_md = 1'b0;
      md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99;
      expect_wr(5'd9, 32'h99);
      step();
      md_valid = 1'b0;
      issue_md = 1'b1; issue_rd = 5'd9;
      step();
      issue_md = 1'b0;
      settle();
      chk("race_busy9", {31'd0, rs2_busy}, 32'd1);
      chk("race_count", {29'd0, fifo_count}, 32'd0);

      query_rd = 5'd15;
      issue_md = 1'b1; issue_rd = 5'd15;
      step();
      issue_md = 1'b0;
      pipe_we = 1'b1; pipe_rd = 5'd3;
      for (int i = 0; i < 2; i++) begin
         pipe_data = 32'h300 + i;
         expect_wr(5'd3, 32'h300 + i);
         md_valid = 1'b1; md_rd = 5'(15 + i); md_data = 32'hF0 + i;
         step();
      end
      md_valid = 1'b0;
      rst = 1'b1;
      settle();
      chk("mid_count", {29'd0, fifo_count}, 32'd2);
      chk("mid_busy15", {31'd0, rd_busy}, 32'd1);
      chk("mid_rst_we", {31'd0, rf_write_enable}, 32'd0);
      step();
      rst = 1'b0; pipe_we = 1'b0;
      settle();
      chk("rst2_count", {29'd0, fifo_count}, 32'd0);
      chk("rst2_busy15", {31'd0, rd_busy}, 32'd0);
      chk("rst2_busy9", {31'd0, rs2_busy}, 32'd0);
      step(); step();
      settle();
      chk("leftover_exp", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
